// File: rtl/mdu_ctrl.sv
// Multiply/divide controller owning HI/LO; optional flush input via MDU_CANCEL_EN.
// Latency: MULT/MULTU MULT_CYCLES, DIV/DIVU DIV_CYCLES busy cycles; MTHI/MTLO write on the accept edge.
// Backpressure: no ready handshake; stall holds D-stage MDU users while busy, starts while busy are dropped.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_mdu,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [31:0] res_hi, res_hi_nxt;
  logic [31:0] res_lo, res_lo_nxt;
  logic        res_wr, res_wr_nxt;
  logic [31:0] hi_nxt, lo_nxt;
  logic        kill;

`ifdef MDU_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif

  logic is_arith, is_div;
  assign is_arith = (op >= OP_MULT) && (op <= OP_DIVU);
  assign is_div   = (op == OP_DIV) || (op == OP_DIVU);

  // Sign-extend only for MULT so one 64-bit multiplier serves both flavours.
  logic        mul_sgn;
  logic [63:0] a_ext, b_ext, prod;
  assign mul_sgn = (op == OP_MULT);
  assign a_ext   = {{32{a[31] & mul_sgn}}, a};
  assign b_ext   = {{32{b[31] & mul_sgn}}, b};
  assign prod    = a_ext * b_ext;

  // Signed divide on magnitudes: 0x80000000 / -1 falls out as 0x80000000 without special casing.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  assign a_neg  = (op == OP_DIV) & a[31];
  assign b_neg  = (op == OP_DIV) & b[31];
  assign a_mag  = a_neg ? (~a + 32'd1) : a;
  assign b_mag  = b_neg ? (~b + 32'd1) : b;
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    res_hi_nxt = res_hi;
    res_lo_nxt = res_lo;
    res_wr_nxt = res_wr;
    hi_nxt     = hi;
    lo_nxt     = lo;
    case (state)
      IDLE: begin
        if (start && !kill) begin
          if (is_arith) begin
            state_nxt  = BUSY;
            cnt_nxt    = is_div ? DIV_LOAD : MULT_LOAD;
            res_hi_nxt = is_div ? rem  : prod[63:32];
            res_lo_nxt = is_div ? quot : prod[31:0];
            // Divide by zero still occupies the unit but leaves HI/LO alone.
            res_wr_nxt = !(is_div && (b == 32'd0));
          end else if (op == OP_MTHI) begin
            hi_nxt = a;
          end else if (op == OP_MTLO) begin
            lo_nxt = a;
          end
        end
      end
      BUSY: begin
        if (kill) begin
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          res_wr_nxt = 1'b0;
        end else if (cnt == 5'd0) begin
          state_nxt  = IDLE;
          res_wr_nxt = 1'b0;
          if (res_wr) begin
            hi_nxt = res_hi;
            lo_nxt = res_lo;
          end
        end else begin
          cnt_nxt = cnt - 5'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_wr <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      res_hi <= res_hi_nxt;
      res_lo <= res_lo_nxt;
      res_wr <= res_wr_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
    end
  end

  assign busy  = (state == BUSY);
  assign stall = reset & d_is_mdu & (busy | (start & is_arith));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomised scoreboard bench for mdu_ctrl with an arithmetic reference model.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_is_mdu;
  logic        cancel_r;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef MDU_CANCEL_EN
    .cancel   (cancel_r),
`endif
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .d_is_mdu (d_is_mdu),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        scb[$];
  int          checks   = 0;
  int          failures = 0;
  int          m_left   = 0;
  logic [31:0] m_hi     = '0;
  logic [31:0] m_lo     = '0;
  logic [31:0] pre_hi   = '0;
  logic [31:0] pre_lo   = '0;
  bit          chk_mt   = 1'b0;
  int          bcnt     = 0;
  logic        prev_busy = 1'b0;

  function automatic bit is_arith(input logic [2:0] o);
    return (o >= 3'd1) && (o <= 3'd4);
  endfunction

  function automatic int lat(input logic [2:0] o);
    return (o >= 3'd3) ? 10 : 5;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: cycle-level busy/stall expectations plus scoreboard pops on write-back events.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_busy;
    bit   exp_stall;
    bit   acc;
    if (!reset) m_left = 0;
    exp_busy  = (m_left > 0);
    exp_stall = reset && d_is_mdu && (exp_busy || (start && is_arith(op)));
    check32("busy", {31'b0, busy}, {31'b0, exp_busy});
    check32("stall", {31'b0, stall}, {31'b0, exp_stall});
    if (chk_mt || (!busy && prev_busy)) begin
      if (scb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scb_underflow actual=write-back required=none");
      end else begin
        e = scb.pop_front();
        check32("hi", hi, e.hi);
        check32("lo", lo, e.lo);
        if (!chk_mt) check32("busy_len", bcnt, e.len);
      end
      bcnt = 0;
    end
    chk_mt = 1'b0;
    if (busy) bcnt++;
    prev_busy = busy;
    acc = reset && !cancel_r && start && (m_left == 0);
    if (m_left > 0) m_left = cancel_r ? 0 : m_left - 1;
    else if (acc && is_arith(op)) m_left = lat(op);
    else if (acc && (op == 3'd5 || op == 3'd6)) chk_mt = 1'b1;
  end

  task automatic model_accept(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int          sa, sb2;
    longint      ps, q, r;
    logic [63:0] pu, pv, qv, rv;
    sa  = x;
    sb2 = y;
    if (is_arith(o)) begin
      pre_hi = m_hi;
      pre_lo = m_lo;
    end
    case (o)
      3'd1: begin
        ps = longint'(sa) * longint'(sb2);
        pv = ps;
        m_hi = pv[63:32];
        m_lo = pv[31:0];
      end
      3'd2: begin
        pu = {32'b0, x} * {32'b0, y};
        m_hi = pu[63:32];
        m_lo = pu[31:0];
      end
      3'd3: if (y != 0) begin
        q = longint'(sa) / longint'(sb2);
        r = longint'(sa) % longint'(sb2);
        qv = q;
        rv = r;
        m_lo = qv[31:0];
        m_hi = rv[31:0];
      end
      3'd4: if (y != 0) begin
        m_lo = x / y;
        m_hi = x % y;
      end
      3'd5: m_hi = x;
      3'd6: m_lo = x;
      default: ;
    endcase
    if (is_arith(o)) scb.push_back('{m_hi, m_lo, lat(o)});
    else if (o == 3'd5 || o == 3'd6) scb.push_back('{m_hi, m_lo, 0});
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic dm, input logic cn);
    @(posedge clk);
    #1;
    start = 1'b1; op = o; a = x; b = y; d_is_mdu = dm; cancel_r = cn;
    if (reset && !cn && m_left == 0) model_accept(o, x, y);
  endtask

  task automatic idle(input int dm);
    @(posedge clk);
    #1;
    start    = 1'($urandom_range(0, 1));
    op       = start ? (($urandom_range(0, 1) != 0) ? 3'd0 : 3'd7) : 3'($urandom_range(0, 7));
    a        = $urandom;
    b        = $urandom;
    d_is_mdu = (dm < 0) ? 1'($urandom_range(0, 1)) : 1'(dm);
    cancel_r = 1'b0;
  endtask

  task automatic wait_idle(input int dm);
    for (int i = 0; i < 64; i++) begin
      idle(dm);
      if (m_left == 0) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_idle_timeout actual=busy required=idle");
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; d_is_mdu = 1'b0; cancel_r = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check32("rst_hi", hi, 32'h0);
    check32("rst_lo", lo, 32'h0);

    drive(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    wait_idle(-1);
    drive(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_idle(-1);
    drive(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    wait_idle(-1);
    drive(3'd4, 32'd7, 32'd0, 1'b0, 1'b0);
    wait_idle(-1);
    drive(3'd5, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    drive(3'd6, 32'h9ABC_DEF0, 32'd0, 1'b1, 1'b0);
    wait_idle(1);

    // DIV with D-stage MDU user held, and an intruding MULT in busy cycle 3.
    drive(3'd3, $urandom, 32'd5, 1'b1, 1'b0);
    drive(3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(3'd1, 32'd9, 32'd9, 1'b1, 1'b0);
    wait_idle(1);
    drive(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_idle(-1);

    // Reset in busy cycle 2 of a MULT.
    drive(3'd1, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
    idle(1);
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b1; op = 3'd1; d_is_mdu = 1'b1;
    scb[scb.size() - 1] = '{32'h0, 32'h0, 1};
    m_hi = '0;
    m_lo = '0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (12) idle(-1);
    @(negedge clk);
    check32("no_wb_hi", hi, 32'h0);
    check32("no_wb_lo", lo, 32'h0);

`ifdef MDU_CANCEL_EN
    drive(3'd6, 32'hCAFE_0001, 32'd0, 1'b0, 1'b0);
    wait_idle(-1);
    drive(3'd3, 32'd100, 32'd7, 1'b1, 1'b0);
    repeat (3) idle(1);
    @(posedge clk);
    #1;
    start = 1'b0; cancel_r = 1'b1;
    scb[scb.size() - 1] = '{pre_hi, pre_lo, 4};
    m_hi = pre_hi;
    m_lo = pre_lo;
    idle(-1);
    drive(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
    idle(-1);
    @(negedge clk);
    check32("cancel_mthi", hi, m_hi);
`endif

    repeat (40) begin
      drive(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 3) == 0)
        drive(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
      wait_idle(-1);
      repeat ($urandom_range(0, 2)) idle(-1);
    end

    repeat (3) idle(-1);
    @(negedge clk);
    check32("scb_drain", 32'(scb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
